level_port_arbiter: RTL

- Shares one single-port level tile memory between two readers: the display pixel fetch path and the collision resolver lookup path.
- Sits between display_controller / collision_resolver and the level tile store, replacing the dual-read-port level arrangement.
- Display path has absolute priority and a fixed latency. Collision path uses a req/ack handshake and is served in free memory slots.

---
 rtl/level_pkg.sv | 23 ++
 rtl/tile_addr_calc.sv | 14 +
 rtl/level_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/level_pkg.sv
// Shared constants, collision FSM states and tile address helper for the level port arbiter.
package level_pkg;
  localparam int BLOCK_W    = 1;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_COLS   = 40;
  localparam int MAP_ROWS   = 30;
  localparam int ADDR_W     = 11;

  localparam logic [BLOCK_W-1:0] OOB_TILE = BLOCK_W'(1);
  localparam logic [9:0]         X_LIM    = 10'(MAP_COLS << TILE_SHIFT);
  localparam logic [9:0]         Y_LIM    = 10'(MAP_ROWS << TILE_SHIFT);

  typedef enum logic [1:0] {IDLE, WAIT, READ, ACK} col_state_e;

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [9:0] x, input logic [9:0] y);
    logic [ADDR_W-1:0] row, col;
    row = ADDR_W'(y >> TILE_SHIFT);
    col = ADDR_W'(x >> TILE_SHIFT);
    // 40 = 32 + 8: shift-add avoids a multiplier for the default map width
    if (MAP_COLS == 40) return (row << 5) + (row << 3) + col;
    return ADDR_W'(row * MAP_COLS) + col;
  endfunction
endpackage

// File: rtl/tile_addr_calc.sv
// Pixel x/y to tile memory address, with out-of-map flag.
module tile_addr_calc
  import level_pkg::*;
(
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              oob_o
);
  always_comb begin
    oob_o  = (x_i >= X_LIM) || (y_i >= Y_LIM);
    addr_o = tile_addr(x_i, y_i);
  end
endmodule

// File: rtl/level_port_arbiter.sv
// Single-port level memory shared by a fixed-latency display path and a req/ack collision path.
// Optional last-tile display cache: define LEVEL_ARB_DISP_CACHE_EN.
module level_port_arbiter
  import level_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               disp_req,
  input  logic [9:0]         disp_x,
  input  logic [9:0]         disp_y,
  output logic               disp_valid,
  output logic [BLOCK_W-1:0] disp_data,
  input  logic               col_req,
  input  logic [9:0]         col_x,
  input  logic [9:0]         col_y,
  output logic               col_ack,
  output logic [BLOCK_W-1:0] col_data,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [BLOCK_W-1:0] mem_rdata,
  output logic [15:0]        col_stall_cnt
);
  logic [ADDR_W-1:0]  disp_addr, col_addr;
  logic               disp_oob, col_oob;
  logic               disp_hit, disp_busy, disp_rd, col_issue, col_rd, stall_inc;
  col_state_e         state_q;
  logic [1:0]         vld_pipe_q;
  logic               d_oob_q, col_ack_q, col_oob_q;
  logic [BLOCK_W-1:0] disp_word, disp_data_q, col_data_q;
  logic [15:0]        stall_q, stall_d;

  tile_addr_calc u_disp_addr (.x_i(disp_x), .y_i(disp_y), .addr_o(disp_addr), .oob_o(disp_oob));
  tile_addr_calc u_col_addr  (.x_i(col_x),  .y_i(col_y),  .addr_o(col_addr),  .oob_o(col_oob));

`ifdef LEVEL_ARB_DISP_CACHE_EN
  logic               cache_vld_q, d_hit_q;
  logic [ADDR_W-1:0]  cache_addr_q;
  logic [BLOCK_W-1:0] cache_data_q;

  assign disp_hit  = cache_vld_q && !disp_oob && (cache_addr_q == disp_addr);
  assign disp_word = d_hit_q ? cache_data_q : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_vld_q  <= 1'b0;
      d_hit_q      <= 1'b0;
      cache_addr_q <= '0;
      cache_data_q <= '0;
    end else begin
      d_hit_q <= disp_hit;
      if (disp_req && disp_oob) cache_vld_q <= 1'b0;
      else if (disp_rd) begin
        cache_addr_q <= disp_addr;
        cache_vld_q  <= 1'b0;
      end
      if (vld_pipe_q[0] && !d_oob_q && !d_hit_q) begin
        cache_data_q <= mem_rdata;
        cache_vld_q  <= 1'b1;
      end
    end
  end
`else
  assign disp_hit  = 1'b0;
  assign disp_word = mem_rdata;
`endif

  // Display owns the port whenever it needs memory; collision only takes free slots.
  assign disp_busy = disp_req && !disp_hit;
  assign disp_rd   = disp_busy && !disp_oob;
  assign col_issue = col_req && !disp_busy && (state_q == IDLE || state_q == WAIT);
  assign col_rd    = col_issue && !col_oob;
  assign stall_inc = col_req && disp_busy && (state_q == IDLE || state_q == WAIT);
  assign stall_d   = (stall_inc && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;

  assign mem_en        = !reset && (disp_rd || col_rd);
  assign mem_addr      = !mem_en ? '0 : (disp_rd ? disp_addr : col_addr);
  assign disp_valid    = vld_pipe_q[1];
  assign disp_data     = disp_data_q;
  assign col_ack       = col_ack_q;
  assign col_data      = col_data_q;
  assign col_stall_cnt = stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      d_oob_q     <= 1'b0;
      disp_data_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], disp_req};
      d_oob_q    <= disp_oob;
      if (vld_pipe_q[0]) disp_data_q <= d_oob_q ? OOB_TILE : disp_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_ack_q  <= 1'b0;
      col_oob_q  <= 1'b0;
      col_data_q <= '0;
      stall_q    <= '0;
    end else begin
      stall_q   <= stall_d;
      col_ack_q <= 1'b0;
      case (state_q)
        IDLE, WAIT: begin
          if (col_issue) begin
            col_oob_q <= col_oob;
            state_q   <= READ;
          end else if (col_req) state_q <= WAIT;
          else                  state_q <= IDLE;
        end
        READ: begin
          col_data_q <= col_oob_q ? OOB_TILE : mem_rdata;
          col_ack_q  <= 1'b1;
          state_q    <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
